// File: rtl/fp_min_sched_pkg.sv
// Shared constants for the multi-client fp_min scheduler: field widths of the
// rounding-mode and status buses, status bit positions, credit counter sizing.
package fp_min_sched_pkg;

   localparam int RND_W    = 2;
   localparam int STATUS_W = 5;

   localparam int ST_NV = 4;
   localparam int ST_DZ = 3;
   localparam int ST_OF = 2;
   localparam int ST_UF = 1;
   localparam int ST_NX = 0;

   // Counter must hold every value from 0 to depth inclusive.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fp_min.sv
// Combinational IEEE-754 minNum: a NaN operand yields the other operand,
// two NaNs yield the canonical quiet NaN, -0 orders below +0.
module fp_min
   import fp_min_sched_pkg::*;
#(
   parameter int SIGN_W = 1,
   parameter int EXPO_W = 8,
   parameter int MANT_W = 23,
   localparam int W = SIGN_W + EXPO_W + MANT_W
) (
   input  logic [W-1:0]        a,
   input  logic [W-1:0]        b,
   input  logic [RND_W-1:0]    rnd,
   output logic [W-1:0]        res,
   output logic [STATUS_W-1:0] status
);

   logic                     a_sign, b_sign;
   logic [EXPO_W-1:0]        a_exp, b_exp;
   logic [MANT_W-1:0]        a_man, b_man;
   logic [EXPO_W+MANT_W-1:0] a_mag, b_mag;
   logic                     a_nan, b_nan, a_snan, b_snan;
   logic                     b_lt_a;
   logic [W-1:0]             canon_nan;
   logic                     unused_rnd;

   // min is exact, so the rounding mode never influences the result
   assign unused_rnd = ^rnd;

   assign a_sign = a[W-1];
   assign b_sign = b[W-1];
   assign a_exp  = a[MANT_W +: EXPO_W];
   assign b_exp  = b[MANT_W +: EXPO_W];
   assign a_man  = a[MANT_W-1:0];
   assign b_man  = b[MANT_W-1:0];
   assign a_mag  = a[EXPO_W+MANT_W-1:0];
   assign b_mag  = b[EXPO_W+MANT_W-1:0];

   assign a_nan  = (&a_exp) && (|a_man);
   assign b_nan  = (&b_exp) && (|b_man);
   assign a_snan = a_nan && !a_man[MANT_W-1];
   assign b_snan = b_nan && !b_man[MANT_W-1];

   assign b_lt_a = (a_sign != b_sign) ? b_sign :
                   (a_sign ? (b_mag > a_mag) : (b_mag < a_mag));

   always_comb begin
      canon_nan = '0;
      canon_nan[MANT_W +: EXPO_W] = '1;
      canon_nan[MANT_W-1] = 1'b1;

      if (a_nan && b_nan) res = canon_nan;
      else if (a_nan)     res = b;
      else if (b_nan)     res = a;
      else if (b_lt_a)    res = b;
      else                res = a;

      status        = '0;
      status[ST_NV] = a_snan || b_snan;
      status[ST_DZ] = 1'b0;
      status[ST_OF] = 1'b0;
      status[ST_UF] = 1'b0;
      status[ST_NX] = 1'b0;
   end

endmodule

// File: rtl/fp_min_rsp_fifo.sv
// Response FIFO; output reads as zero while empty so the response bus idles at 0.
module fp_min_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push, do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage has no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/fp_min_sched.sv
// Round-robin front end sharing one registered fp_min stage among NUM_REQ
// clients; credits reserve response FIFO space so the stage never stalls.
module fp_min_sched
   import fp_min_sched_pkg::*;
#(
   parameter int SIGN_W    = 1,
   parameter int EXPO_W    = 8,
   parameter int MANT_W    = 23,
   parameter int NUM_REQ   = 4,
   parameter int RSP_DEPTH = 4,
   localparam int W        = SIGN_W + EXPO_W + MANT_W,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*W-1:0]     req_ina,
   input  logic [NUM_REQ*W-1:0]     req_inb,
   input  logic [NUM_REQ*RND_W-1:0] req_rnd,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [W-1:0]             rsp_res,
   output logic [STATUS_W-1:0]      rsp_status,
   output logic                     busy,
   input  logic                     flags_clr,
   output logic [STATUS_W-1:0]      flags_acc
);

   localparam int IDX_W = ID_W + 1;
   localparam int CRD_W = credit_w(RSP_DEPTH);
   localparam int ENT_W = ID_W + W + STATUS_W;

   logic [ID_W-1:0]     prio_reg;
   logic [CRD_W-1:0]    credit_reg;
   logic                s1_valid_reg;
   logic [ID_W-1:0]     s1_id_reg;
   logic [W-1:0]        s1_a_reg, s1_b_reg;
   logic [RND_W-1:0]    s1_rnd_reg;
   logic [STATUS_W-1:0] flags_reg;

   logic                grant_found;
   logic [ID_W-1:0]     grant_id;
   logic [IDX_W-1:0]    idx;
   logic                credit_ok, xfer, pop;
   logic [W-1:0]        min_res;
   logic [STATUS_W-1:0] min_status;
   logic [ENT_W-1:0]    fifo_dout;
   logic                fifo_empty, fifo_full_unused;

   // First valid requester at or after prio_reg, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, prio_reg} + IDX_W'(k);
         if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
         if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = idx[ID_W-1:0];
         end
      end
   end

   assign credit_ok = rst_n && (credit_reg != '0);
   assign xfer      = grant_found && credit_ok;
   assign req_ready = xfer ? (NUM_REQ'(1) << grant_id) : '0;
   assign pop       = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_reg     <= '0;
         credit_reg   <= CRD_W'(RSP_DEPTH);
         s1_valid_reg <= 1'b0;
         s1_id_reg    <= '0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_rnd_reg   <= '0;
         flags_reg    <= '0;
      end else begin
         s1_valid_reg <= xfer;
         if (xfer) begin
            s1_id_reg  <= grant_id;
            s1_a_reg   <= req_ina[grant_id*W +: W];
            s1_b_reg   <= req_inb[grant_id*W +: W];
            s1_rnd_reg <= req_rnd[grant_id*RND_W +: RND_W];
            prio_reg   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         end

         case ({xfer, pop})
            2'b10:   credit_reg <= credit_reg - CRD_W'(1);
            2'b01:   credit_reg <= credit_reg + CRD_W'(1);
            default: credit_reg <= credit_reg;
         endcase

         // A pop coinciding with a clear loads the popped status.
         if (pop)            flags_reg <= flags_clr ? rsp_status : (flags_reg | rsp_status);
         else if (flags_clr) flags_reg <= '0;
      end
   end

   fp_min #(
      .SIGN_W (SIGN_W),
      .EXPO_W (EXPO_W),
      .MANT_W (MANT_W)
   ) u_fp_min (
      .a      (s1_a_reg),
      .b      (s1_b_reg),
      .rnd    (s1_rnd_reg),
      .res    (min_res),
      .status (min_status)
   );

   fp_min_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (ENT_W)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s1_valid_reg),
      .din   ({s1_id_reg, min_res, min_status}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full_unused),
      .empty (fifo_empty)
   );

   assign rsp_valid = !fifo_empty;
   assign {rsp_id, rsp_res, rsp_status} = fifo_dout;
   assign busy      = s1_valid_reg || !fifo_empty;
   assign flags_acc = flags_reg;

endmodule
